// File: rtl/alu_wb_stage_pkg.sv
// Shared types and constants for the ALU writeback stage: opcodes, the
// writeback beat layout and the skid-buffer occupancy states.
package alu_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;
   localparam int OP_W      = 5;

   localparam logic [OP_W-1:0] OP_ADD      = 5'h00;
   localparam logic [OP_W-1:0] OP_SUB      = 5'h02;
   localparam logic [OP_W-1:0] OP_AND      = 5'h05;
   localparam logic [OP_W-1:0] OP_OR       = 5'h06;
   localparam logic [OP_W-1:0] OP_XOR      = 5'h07;
   localparam logic [OP_W-1:0] OP_SLL      = 5'h08;
   localparam logic [OP_W-1:0] OP_SRL      = 5'h09;
   localparam logic [OP_W-1:0] OP_SRA      = 5'h0A;
   localparam logic [OP_W-1:0] OP_FLAG_MAX = 5'h0A;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data;
      logic [WB_REG_AW-1:0] addr;
      logic                 we;
   } wb_beat_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

   // Only the arithmetic/logic/shift group writes the condition codes.
   function automatic logic op_sets_flags(input logic [OP_W-1:0] op);
      return op <= OP_FLAG_MAX;
   endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// Handshake bundle between the ALU (master) and the writeback stage (slave),
// including the downstream register-file port driven by the stage.
interface alu_wb_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_z;
   logic              in_v;
   logic              in_n;
   logic [4:0]        in_opcode;
   logic [REG_AW-1:0] in_rd;
   logic              in_wr_en;

   logic              wb_valid;
   logic              wb_ready;
   logic [DATA_W-1:0] wb_data;
   logic [REG_AW-1:0] wb_addr;
   logic              wb_we;

   modport master (
      output in_valid, in_result, in_z, in_v, in_n, in_opcode, in_rd, in_wr_en,
      output wb_ready,
      input  in_ready, wb_valid, wb_data, wb_addr, wb_we
   );

   modport slave (
      input  in_valid, in_result, in_z, in_v, in_n, in_opcode, in_rd, in_wr_en,
      input  wb_ready,
      output in_ready, wb_valid, wb_data, wb_addr, wb_we
   );
endinterface

// File: rtl/alu_wb_stage_wb_skid_buf.sv
// Two-entry FIFO-ordered skid buffer; entry 0 is always the head presented
// downstream, and ready is registered so it never depends on the pop side.
module wb_skid_buf
   import alu_pkg::*;
#(
   parameter int W = $bits(wb_beat_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         ready
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] ent0_q, ent0_d;
   logic [W-1:0] ent1_q, ent1_d;
   logic         ready_q, ready_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SKID_EMPTY;
         ent0_q  <= '0;
         ent1_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      unique case (state_q)
         SKID_EMPTY: begin
            if (push) begin
               ent0_d  = push_data;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (push && pop) begin
               ent0_d = push_data;
            end else if (push) begin
               ent1_d  = push_data;
               state_d = SKID_TWO;
            end else if (pop) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            // ready is low here, so only the drain side can move
            if (pop) begin
               ent0_d  = ent1_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      if (flush) state_d = SKID_EMPTY;
      ready_d = (state_d != SKID_TWO);
   end

   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = ent0_q;
   assign ready     = ready_q;

endmodule

// File: rtl/alu_wb_stage.sv
// Execute->writeback stage: buffers ALU beats toward the register file,
// commits condition codes at accept time and counts retired beats.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   alu_wb_stage_if.slave    bus,
   output logic             ccr_z,
   output logic             ccr_v,
   output logic             ccr_n,
   output logic             ccr_upd,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int BEAT_W = DATA_W + REG_AW + 1;

   logic [BEAT_W-1:0] beat_in;
   logic [BEAT_W-1:0] beat_out;
   logic              skid_ready;
   logic              skid_valid;
   logic              accept;
   logic              drain;
   logic              we_in;

   logic [2:0]        ccr_q, ccr_d;
   logic              ccr_upd_q, ccr_upd_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

   // A flushed beat is dropped entirely: not buffered, no flag update.
   assign accept  = bus.in_valid & skid_ready & ~flush;
   assign drain   = skid_valid & bus.wb_ready;
   assign we_in   = bus.in_wr_en & (bus.in_rd != '0);
   assign beat_in = {bus.in_result, bus.in_rd, we_in};

   wb_skid_buf #(
      .W (BEAT_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (accept),
      .push_data (beat_in),
      .pop       (drain),
      .out_valid (skid_valid),
      .out_data  (beat_out),
      .ready     (skid_ready)
   );

   assign bus.in_ready = skid_ready;
   assign bus.wb_valid = skid_valid;
   assign bus.wb_data  = beat_out[BEAT_W-1 -: DATA_W];
   assign bus.wb_addr  = beat_out[REG_AW:1];
   assign bus.wb_we    = beat_out[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         ccr_q        <= '0;
         ccr_upd_q    <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         ccr_q        <= ccr_d;
         ccr_upd_q    <= ccr_upd_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Flags commit at accept so the following instruction sees them even
   // while this beat is still stalled in the buffer.
   always_comb begin
      ccr_d        = ccr_q;
      ccr_upd_d    = 1'b0;
      retire_cnt_d = retire_cnt_q + CNT_W'(drain);
      if (accept && op_sets_flags(bus.in_opcode)) begin
         ccr_d     = {bus.in_z, bus.in_v, bus.in_n};
         ccr_upd_d = 1'b1;
      end
   end

   assign ccr_z      = ccr_q[2];
   assign ccr_v      = ccr_q[1];
   assign ccr_n      = ccr_q[0];
   assign ccr_upd    = ccr_upd_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus randomized
// traffic scored against a queue-based model of the stage.
module tb_alu_wb_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        ccr_z, ccr_v, ccr_n, ccr_upd;
   logic [15:0] retire_cnt;

   alu_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   alu_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .bus        (bus.slave),
      .ccr_z      (ccr_z),
      .ccr_v      (ccr_v),
      .ccr_n      (ccr_n),
      .ccr_upd    (ccr_upd),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a queue of pending beats plus architectural state.
   wb_beat_t    mq[$];
   logic [2:0]  m_ccr = '0;
   logic        m_upd = 1'b0;
   logic [15:0] m_cnt = '0;
   logic        m_ready = 1'b0;

   task automatic tick();
      logic acc, drn;
      wb_beat_t b;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ccr = '0; m_upd = 1'b0; m_cnt = '0; m_ready = 1'b0;
      end else begin
         acc = bus.in_valid && m_ready && !flush;
         drn = (mq.size() > 0) && bus.wb_ready;
         if (drn) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         m_upd = 1'b0;
         if (flush) begin
            mq.delete();
         end else if (acc) begin
            b.data = bus.in_result;
            b.addr = bus.in_rd;
            b.we   = bus.in_wr_en && (bus.in_rd != 5'd0);
            mq.push_back(b);
            if (bus.in_opcode <= 5'h0A) begin
               m_ccr = {bus.in_z, bus.in_v, bus.in_n};
               m_upd = 1'b1;
            end
         end
         m_ready = (mq.size() < 2);
      end
      #1;
   endtask

   task automatic drive(input logic vld, input logic [31:0] res, input logic [4:0] rd,
                        input logic [4:0] op, input logic z, input logic v, input logic n,
                        input logic wr);
      bus.in_valid  = vld;
      bus.in_result = res;
      bus.in_rd     = rd;
      bus.in_opcode = op;
      bus.in_z      = z;
      bus.in_v      = v;
      bus.in_n      = n;
      bus.in_wr_en  = wr;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({bus.wb_valid, bus.in_ready, bus.wb_we, ccr_z, ccr_v, ccr_n, ccr_upd} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl cyc=%0d got=%b exp=0", i,
                     {bus.wb_valid, bus.in_ready, bus.wb_we, ccr_z, ccr_v, ccr_n, ccr_upd});
         end
         n_cmp++;
         if ({bus.wb_data, bus.wb_addr, retire_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got data=%h addr=%h cnt=%h exp=0", bus.wb_data, bus.wb_addr, retire_cnt);
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b1 || retire_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL post_reset got ready=%b cnt=%0d exp ready=1 cnt=0", bus.in_ready, retire_cnt);
      end
   endtask

   task automatic test_single();
      bus.wb_ready = 1'b1;
      drive(1'b1, 32'h0000_0005, 5'd3, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd5 || bus.wb_addr !== 5'd3 || bus.wb_we !== 1'b1) begin
         n_bad++;
         $display("FAIL single_beat got v=%b d=%h a=%0d we=%b exp v=1 d=5 a=3 we=1",
                  bus.wb_valid, bus.wb_data, bus.wb_addr, bus.wb_we);
      end
      n_cmp++;
      if (ccr_upd !== 1'b1) begin
         n_bad++;
         $display("FAIL single_upd got=%b exp=1", ccr_upd);
      end
      tick();
      n_cmp++;
      if (retire_cnt !== 16'd1 || bus.wb_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_retire got cnt=%0d v=%b exp cnt=1 v=0", retire_cnt, bus.wb_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, c;
      logic [15:0] cnt0;
      a = $urandom; b = $urandom; c = $urandom;
      cnt0 = m_cnt;
      bus.wb_ready = 1'b0;
      drive(1'b1, a, 5'd1, OP_OR, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b1, b, 5'd2, OP_OR, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b1, c, 5'd4, OP_OR, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_data !== a) begin
            n_bad++;
            $display("FAIL b2b_hold i=%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=%h",
                     i, bus.in_ready, bus.wb_valid, bus.wb_data, a);
         end
         tick();
      end
      bus.wb_ready = 1'b1;
      tick();
      n_cmp++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== b) begin
         n_bad++;
         $display("FAIL b2b_order_b got v=%b d=%h exp d=%h", bus.wb_valid, bus.wb_data, b);
      end
      tick();
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== c || bus.wb_addr !== 5'd4) begin
         n_bad++;
         $display("FAIL b2b_order_c got v=%b d=%h a=%0d exp d=%h a=4", bus.wb_valid, bus.wb_data, bus.wb_addr, c);
      end
      tick();
      n_cmp++;
      if (bus.wb_valid !== 1'b0 || retire_cnt !== cnt0 + 16'd3) begin
         n_bad++;
         $display("FAIL b2b_count got v=%b cnt=%0d exp v=0 cnt=%0d", bus.wb_valid, retire_cnt, cnt0 + 16'd3);
      end
   endtask

   task automatic test_ccr();
      bus.wb_ready = 1'b1;
      drive(1'b1, 32'd7, 5'd1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      n_cmp++;
      if (ccr_z !== 1'b0 || ccr_upd !== 1'b1) begin
         n_bad++;
         $display("FAIL ccr_add got z=%b upd=%b exp z=0 upd=1", ccr_z, ccr_upd);
      end
      drive(1'b1, 32'd0, 5'd1, 5'h0C, 1'b1, 1'b1, 1'b1, 1'b1); tick();
      n_cmp++;
      if (ccr_z !== 1'b0 || ccr_upd !== 1'b0) begin
         n_bad++;
         $display("FAIL ccr_nonflag got z=%b upd=%b exp z=0 upd=0", ccr_z, ccr_upd);
      end
      drive(1'b1, 32'd0, 5'd1, OP_AND, 1'b1, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({ccr_z, ccr_v, ccr_n} !== 3'b100 || ccr_upd !== 1'b1) begin
         n_bad++;
         $display("FAIL ccr_and got zvn=%b upd=%b exp zvn=100 upd=1", {ccr_z, ccr_v, ccr_n}, ccr_upd);
      end
      tick();
   endtask

   task automatic test_rd0();
      logic [15:0] cnt0;
      cnt0 = m_cnt;
      bus.wb_ready = 1'b1;
      drive(1'b1, 32'hDEAD_BEEF, 5'd0, OP_XOR, 1'b0, 1'b0, 1'b1, 1'b1); tick();
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0 || bus.wb_data !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL rd0_beat got v=%b we=%b d=%h exp v=1 we=0 d=deadbeef", bus.wb_valid, bus.wb_we, bus.wb_data);
      end
      tick();
      n_cmp++;
      if (retire_cnt !== cnt0 + 16'd1) begin
         n_bad++;
         $display("FAIL rd0_count got=%0d exp=%0d", retire_cnt, cnt0 + 16'd1);
      end
   endtask

   task automatic test_flush(input logic drain_in_flush);
      logic [2:0]  ccr0;
      logic [15:0] cnt0;
      bus.wb_ready = 1'b0;
      drive(1'b1, $urandom, 5'd5, OP_SLL, 1'b0, 1'b0, 1'b1, 1'b1); tick();
      drive(1'b1, $urandom, 5'd6, OP_SRL, 1'b0, 1'b1, 1'b0, 1'b1); tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_full got rdy=%b v=%b exp rdy=0 v=1", bus.in_ready, bus.wb_valid);
      end
      ccr0 = {ccr_z, ccr_v, ccr_n};
      cnt0 = retire_cnt;
      bus.wb_ready = drain_in_flush;
      flush = 1'b1;
      drive(1'b1, 32'd0, 5'd7, OP_SUB, 1'b1, 1'b0, 1'b0, 1'b1); tick();
      flush = 1'b0;
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_empty got v=%b rdy=%b exp v=0 rdy=1", bus.wb_valid, bus.in_ready);
      end
      n_cmp++;
      if ({ccr_z, ccr_v, ccr_n} !== ccr0 || ccr_upd !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_ccr got zvn=%b upd=%b exp zvn=%b upd=0", {ccr_z, ccr_v, ccr_n}, ccr_upd, ccr0);
      end
      n_cmp++;
      if (retire_cnt !== cnt0 + 16'(drain_in_flush)) begin
         n_bad++;
         $display("FAIL flush_count got=%0d exp=%0d", retire_cnt, cnt0 + 16'(drain_in_flush));
      end
      // Flush in the one-entry state where the incoming SUB would otherwise be accepted.
      bus.wb_ready = 1'b0;
      drive(1'b1, 32'd9, 5'd8, OP_SRA, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      ccr0 = {ccr_z, ccr_v, ccr_n};
      flush = 1'b1;
      drive(1'b1, 32'd0, 5'd9, OP_SUB, 1'b1, 1'b1, 1'b1, 1'b1); tick();
      flush = 1'b0;
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.wb_valid !== 1'b0 || {ccr_z, ccr_v, ccr_n} !== ccr0 || ccr_upd !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_one got v=%b zvn=%b upd=%b exp v=0 zvn=%b upd=0",
                  bus.wb_valid, {ccr_z, ccr_v, ccr_n}, ccr_upd, ccr0);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst   = (cyc == 200);
         flush = ($urandom_range(0, 19) == 0);
         bus.wb_ready = ($urandom_range(0, 2) != 0);
         drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 5'($urandom_range(0, 15)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick();
         n_cmp++;
         if (bus.wb_valid !== (mq.size() > 0) || bus.in_ready !== m_ready) begin
            n_bad++;
            $display("FAIL rnd_hs cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b",
                     cyc, bus.wb_valid, bus.in_ready, mq.size() > 0, m_ready);
         end
         if (mq.size() > 0) begin
            n_cmp++;
            if (bus.wb_data !== mq[0].data || bus.wb_addr !== mq[0].addr || bus.wb_we !== mq[0].we) begin
               n_bad++;
               $display("FAIL rnd_beat cyc=%0d got d=%h a=%0d we=%b exp d=%h a=%0d we=%b", cyc,
                        bus.wb_data, bus.wb_addr, bus.wb_we, mq[0].data, mq[0].addr, mq[0].we);
            end
         end
         n_cmp++;
         if ({ccr_z, ccr_v, ccr_n} !== m_ccr || ccr_upd !== m_upd || retire_cnt !== m_cnt) begin
            n_bad++;
            $display("FAIL rnd_state cyc=%0d got zvn=%b upd=%b cnt=%0d exp zvn=%b upd=%b cnt=%0d", cyc,
                     {ccr_z, ccr_v, ccr_n}, ccr_upd, retire_cnt, m_ccr, m_upd, m_cnt);
         end
      end
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.wb_ready = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic test_wrap();
      int guard = 0;
      bus.wb_ready = 1'b1;
      while (m_cnt != 16'hFFFF && guard < 70000) begin
         drive(1'b1, $urandom, 5'($urandom), OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
         guard++;
      end
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (guard >= 70000 || retire_cnt !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL wrap_max got=%h exp=ffff guard=%0d", retire_cnt, guard);
      end
      tick();
      tick();
      n_cmp++;
      if (retire_cnt !== m_cnt || m_cnt > 16'd1) begin
         n_bad++;
         $display("FAIL wrap_zero got=%h exp=%h", retire_cnt, m_cnt);
      end
   endtask

   initial begin
      drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.wb_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_ccr();
      test_rd0();
      test_flush(1'b0);
      test_flush(1'b1);
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
